// File: rtl/lib_pkg.sv
// lib_pkg: shared types and constants for the lib_* building blocks.
package lib_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/lib_reg_en_arst.sv
// lib_reg_en_arst: register with load enable and asynchronous active-low reset.
module lib_reg_en_arst #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            q_o <= RESET_VAL;
        else if (en_i)
            q_o <= d_i;
    end

endmodule

// File: rtl/lib_skid_buf.sv
// lib_skid_buf: two-entry valid/ready register slice; s_ready and all outputs
// are decoded from registers, so backpressure is pipelined by one stage.
module lib_skid_buf
    import lib_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       count
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
    logic             main_en, skid_en;
    logic             s_fire, m_fire;

    assign m_valid = (state_q != SKID_EMPTY);
    assign s_ready = (state_q != SKID_TWO);
    assign m_data  = main_q;
    assign count   = state_q;
    assign s_fire  = s_valid & s_ready;
    assign m_fire  = m_valid & m_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= SKID_EMPTY;
        else
            state_q <= state_d;
    end

    // Skid only ever captures the younger word; main refills from skid on drain.
    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = flush ? RESET_VAL : s_data;
        skid_d  = flush ? RESET_VAL : s_data;
        if (flush) begin
            state_d = SKID_EMPTY;
            main_en = 1'b1;
            skid_en = 1'b1;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (s_fire) begin
                        main_en = 1'b1;
                        state_d = SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (s_fire && m_fire) begin
                        main_en = 1'b1;
                    end else if (s_fire) begin
                        skid_en = 1'b1;
                        state_d = SKID_TWO;
                    end else if (m_fire) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    if (m_fire) begin
                        main_en = 1'b1;
                        main_d  = skid_q;
                        state_d = SKID_ONE;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    lib_reg_en_arst #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (main_en),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    lib_reg_en_arst #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (skid_en),
        .d_i    (skid_d),
        .q_o    (skid_q)
    );

endmodule

// File: tb/tb_lib_skid_buf.sv
// tb_lib_skid_buf: directed and random stimulus against a queue scoreboard.
module tb_lib_skid_buf;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic [1:0] count;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    lib_skid_buf #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .count   (count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(count), q.size());
        chk({tag, ".m_valid"}, 32'(m_valid), 32'(q.size() != 0));
        chk({tag, ".s_ready"}, 32'(s_ready), 32'(q.size() < 2));
        if (q.size() != 0)
            chk({tag, ".m_data"}, 32'(m_data), 32'(q[0]));
    endtask

    // Drives one cycle from a negedge; the model follows the handshakes seen
    // just before the rising edge and the DUT is checked at the next negedge.
    task automatic step(input string tag, input logic sv, input logic [7:0] sd,
                        input logic mr, input logic fl);
        logic       hold;
        logic [7:0] held;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
        #1;
        if (m_valid && m_ready && q.size() != 0)
            void'(q.pop_front());
        if (s_valid && s_ready && !fl)
            q.push_back(s_data);
        if (fl)
            q.delete();
        hold = m_valid && !m_ready && !fl;
        held = m_data;
        @(posedge clk);
        @(negedge clk);
        check_state(tag);
        if (hold)
            chk({tag, ".stable"}, 32'(m_data), 32'(held));
    endtask

    initial begin
        logic       pend;
        logic [7:0] pdata;
        logic       sv;
        logic       mr;
        logic [7:0] sd;

        // Reset held with a word offered: nothing is taken.
        s_valid = 1'b1;
        s_data  = 8'hAA;
        repeat (3) @(negedge clk);
        chk("rst.m_valid", 32'(m_valid), 32'd0);
        chk("rst.s_ready", 32'(s_ready), 32'd1);
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.m_data", 32'(m_data), 32'h00);
        rst = 1'b1;
        step("rst_rel", 1'b1, 8'hAA, 1'b0, 1'b0);
        chk("rst_rel.data", 32'(m_data), 32'hAA);
        step("drain0", 1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 1; i <= 16; i++)
            step("stream", 1'b1, 8'(i), 1'b1, 1'b0);
        step("stream_end", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("stream.empty", 32'(count), 32'd0);

        step("bp1", 1'b1, 8'h11, 1'b0, 1'b0);
        step("bp2", 1'b1, 8'h22, 1'b0, 1'b0);
        chk("bp.full", 32'(count), 32'd2);
        step("bp_hold", 1'b1, 8'h99, 1'b0, 1'b0);
        step("bp_out1", 1'b0, 8'h00, 1'b1, 1'b0);
        step("bp_out2", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("bp.empty", 32'(count), 32'd0);

        step("sim_a", 1'b1, 8'h33, 1'b0, 1'b0);
        step("sim_b", 1'b1, 8'h44, 1'b1, 1'b0);
        chk("sim.data", 32'(m_data), 32'h44);
        chk("sim.count", 32'(count), 32'd1);
        step("sim_drain", 1'b0, 8'h00, 1'b1, 1'b0);

        step("fl_a", 1'b1, 8'h55, 1'b0, 1'b0);
        step("fl_b", 1'b1, 8'h66, 1'b0, 1'b0);
        chk("fl.full", 32'(count), 32'd2);
        step("fl", 1'b1, 8'h77, 1'b0, 1'b1);
        chk("fl.data", 32'(m_data), 32'h00);
        chk("fl.count", 32'(count), 32'd0);
        repeat (3) step("fl_after", 1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a cycle with two words buffered.
        step("ar_a", 1'b1, 8'hC1, 1'b0, 1'b0);
        step("ar_b", 1'b1, 8'hC2, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        q.delete();
        chk("arst.m_valid", 32'(m_valid), 32'd0);
        chk("arst.count", 32'(count), 32'd0);
        chk("arst.m_data", 32'(m_data), 32'h00);
        chk("arst.s_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        step("ar_rel", 1'b1, 8'hD0, 1'b1, 1'b0);
        step("ar_drain", 1'b0, 8'h00, 1'b1, 1'b0);

        pend  = 1'b0;
        pdata = 8'h00;
        for (int i = 0; i < 10000; i++) begin
            sv = pend ? 1'b1 : 1'($urandom_range(0, 1));
            sd = pend ? pdata : 8'($urandom);
            mr = 1'($urandom_range(0, 2) != 0);
            pend  = sv && !s_ready;
            pdata = sd;
            step("rand", sv, sd, mr, 1'b0);
        end
        repeat (3) step("rand_drain", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("rand.empty", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
